// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory read port,
// holds each fetched word in an instruction register and hands it to the
// control unit with a valid/ack handshake, redirecting the PC on jumps.
// Optional feature: define IFU_FETCH_COUNT_EN to build the saturating
// delivered-instruction counter; otherwise fetch_count is tied to zero.
module instr_fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_rd,
    output logic [5:0]  imem_addr,
    input  logic [19:0] imem_rdata,
    output logic [19:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        jump_en,
    input  logic [5:0]  jump_addr,
    input  logic        halt,
    output logic [5:0]  pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned INSTR_W = 20;
    localparam int unsigned CNT_W   = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic               accept;
    logic               load;
    logic [ADDR_W-1:0]  pc_next;

    // Halt wins over any ack; a read in flight during WAIT is dropped.
    assign accept  = (state_q == S_HOLD) && instr_ack && !halt;
    assign load    = (state_q == S_WAIT) && !halt;
    assign pc_next = jump_en ? jump_addr : pc + ADDR_W'(1);

    assign imem_addr = pc;

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_ISSUE;
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT:   state_d = S_HOLD;
            S_HOLD:   if (instr_ack) state_d = S_ISSUE;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
        if (halt && (state_q != S_HALTED)) begin
            state_d = S_HALTED;
        end
    end

    // State register and registered status outputs derived from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            imem_rd     <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_rd     <= (state_d == S_ISSUE);
            instr_valid <= (state_d == S_HOLD);
            halted      <= (state_d == S_HALTED);
        end
    end

    // Program counter: advances or jumps only on an accepted ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (accept) begin
            pc <= pc_next;
        end
    end

    // Instruction register: captures read data at the end of WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
        end else if (load) begin
            instr <= INSTR_W'(imem_rdata);
        end
    end

`ifdef IFU_FETCH_COUNT_EN
    logic [CNT_W-1:0] fetch_count_q;

    // Saturating count of delivered instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
        end else if (accept && (fetch_count_q != {CNT_W{1'b1}})) begin
            fetch_count_q <= fetch_count_q + CNT_W'(1);
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: behavioural model plus directed scenarios.
// Counter checks follow IFU_FETCH_COUNT_EN as defined for the build.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_rd;
    logic [5:0]  imem_addr;
    logic [19:0] imem_rdata;
    logic [19:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic        jump_en;
    logic [5:0]  jump_addr;
    logic        halt;
    logic [5:0]  pc;
    logic        halted;
    logic [15:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [19:0] mem [64];
    bit          sat_req = 1'b0;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ack(instr_ack), .jump_en(jump_en), .jump_addr(jump_addr),
        .halt(halt), .pc(pc), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Memory returns the addressed word the cycle after a read strobe.
    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem[imem_addr];
    end

    // Model: fetch cycle offset (-1 start, 0 issue, 1 wait, 2 presenting).
    logic [5:0]  m_pc;
    logic [19:0] m_instr;
    logic        m_valid, m_rd, m_halted;
    logic [15:0] m_count;
    int          m_ofs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 6'd0; m_instr <= 20'd0; m_valid <= 1'b0; m_rd <= 1'b0;
            m_halted <= 1'b0; m_count <= 16'd0; m_ofs <= -1;
        end else begin
            if (m_halted) begin
                m_ofs <= m_ofs;
            end else if (halt) begin
                m_halted <= 1'b1; m_valid <= 1'b0; m_rd <= 1'b0;
            end else if (m_ofs == -1) begin
                m_ofs <= 0; m_rd <= 1'b1;
            end else if (m_ofs == 0) begin
                m_ofs <= 1; m_rd <= 1'b0;
            end else if (m_ofs == 1) begin
                m_instr <= mem[m_pc]; m_valid <= 1'b1; m_ofs <= 2;
            end else if (instr_ack) begin
                m_pc <= jump_en ? jump_addr : 6'((int'(m_pc) + 1) % 64);
                m_valid <= 1'b0; m_rd <= 1'b1; m_ofs <= 0;
`ifdef IFU_FETCH_COUNT_EN
                if (m_count != 16'hFFFF) m_count <= m_count + 16'd1;
`endif
            end
`ifdef IFU_FETCH_COUNT_EN
            if (sat_req) m_count <= 16'hFFFF;
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; waits (bounded) until an instruction is presented.
    task automatic wait_hold(output int w);
        w = 0;
        while (!instr_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!instr_valid) chk("hold_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic do_ack(input bit j, input logic [5:0] a);
        int w;
        wait_hold(w);
        instr_ack = 1'b1; jump_en = j; jump_addr = a;
        @(negedge clk);
        instr_ack = 1'b0; jump_en = 1'b0;
    endtask

    initial begin
        int w;
        logic [19:0] old_instr;

        for (int i = 0; i < 64; i++) mem[i] = 20'((i * 20'h1357 + 20'h0A5) ^ (i << 16));
        mem[0] = 20'h2_5000;
        rst_n = 1'b0; instr_ack = 1'b0; jump_en = 1'b0; jump_addr = 6'd0; halt = 1'b0;

        // Per-cycle comparison against the model.
        fork
            forever begin
                @(negedge clk);
                chk("m_imem_rd", 32'(imem_rd), 32'(m_rd));
                chk("m_imem_addr", 32'(imem_addr), 32'(m_pc));
                chk("m_pc", 32'(pc), 32'(m_pc));
                chk("m_instr", 32'(instr), 32'(m_instr));
                chk("m_instr_valid", 32'(instr_valid), 32'(m_valid));
                chk("m_halted", 32'(halted), 32'(m_halted));
                if (!sat_req) chk("m_fetch_count", 32'(fetch_count), 32'(m_count));
            end
        join_none

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_rd", 32'(imem_rd), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);

        // Start-up latency.
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("start_rd", 32'(imem_rd), 32'd1);
        chk("start_addr", 32'(imem_addr), 32'd0);
        @(posedge clk); #1;
        chk("start_wait_rd", 32'(imem_rd), 32'd0);
        @(posedge clk); #1;
        chk("start_valid", 32'(instr_valid), 32'd1);
        chk("start_instr", 32'(instr), 32'h25000);
        @(negedge clk);

        // Sequential fetch at full rate.
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                wait_hold(w);
                chk("seq_cadence", 32'(w), 32'd2);
            end
            chk("seq_addr", 32'(pc), 32'(k));
            chk("seq_instr", 32'(instr), 32'(mem[k]));
            do_ack(1'b0, 6'd0);
        end

        // Delayed ack holds everything stable.
        wait_hold(w);
        repeat (5) begin
            @(negedge clk);
            chk("dly_valid", 32'(instr_valid), 32'd1);
            chk("dly_pc", 32'(pc), 32'd4);
            chk("dly_instr", 32'(instr), 32'(mem[4]));
            chk("dly_rd", 32'(imem_rd), 32'd0);
        end
        do_ack(1'b0, 6'd0);
        chk("dly_pc_next", 32'(pc), 32'd5);

        // Jump to 63, then wrap to 0.
        do_ack(1'b1, 6'd63);
        chk("jmp_pc", 32'(pc), 32'd63);
        wait_hold(w);
        chk("jmp_instr", 32'(instr), 32'(mem[63]));
        do_ack(1'b0, 6'd0);
        chk("wrap_pc", 32'(pc), 32'd0);

        // Jump/ack outside presentation is ignored (ISSUE then WAIT).
        jump_en = 1'b1; jump_addr = 6'd20; instr_ack = 1'b1;
        repeat (2) @(negedge clk);
        jump_en = 1'b0; instr_ack = 1'b0;
        chk("ign_pc", 32'(pc), 32'd0);
        chk("ign_valid", 32'(instr_valid), 32'd1);
        do_ack(1'b1, 6'd5);
        wait_hold(w);
        chk("pre_halt_pc", 32'(pc), 32'd5);

        // Halt beats a simultaneous ack.
        halt = 1'b1; instr_ack = 1'b1;
        @(negedge clk);
        halt = 1'b0; instr_ack = 1'b0;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd5);
        repeat (3) begin
            @(negedge clk);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_rd", 32'(imem_rd), 32'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_pc", 32'(pc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Counter.
        repeat (10) do_ack(1'b0, 6'd0);
        wait_hold(w);
`ifdef IFU_FETCH_COUNT_EN
        chk("cnt_10", 32'(fetch_count), 32'd10);
        force dut.fetch_count_q = 16'hFFFF;
        sat_req = 1'b1;
        @(posedge clk); #1;
        release dut.fetch_count_q;
        sat_req = 1'b0;
        @(negedge clk);
        chk("cnt_forced", 32'(fetch_count), 32'hFFFF);
        do_ack(1'b0, 6'd0);
        wait_hold(w);
        chk("cnt_sat", 32'(fetch_count), 32'hFFFF);
`else
        chk("cnt_off", 32'(fetch_count), 32'd0);
`endif

        // Halt during WAIT drops the in-flight read.
        old_instr = instr;
        do_ack(1'b0, 6'd0);
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("hwait_halted", 32'(halted), 32'd1);
        chk("hwait_instr", 32'(instr), 32'(old_instr));
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
